mmu_dread: RTL

MMU_DREAD -- requirements
Module: mmu_dread

---
 rtl/mmu_pkg.sv | 17 +
 rtl/mmu_dread_if.sv | 34 +++
 rtl/dread_buf.sv | 50 +++++
 rtl/mmu_dread.sv | 105 ++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the data-read MMU: FSM encoding and line-buffer geometry.
package mmu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } mmu_state_e;

    localparam logic [1:0] WordOff = 2'b00;
    localparam int unsigned TagW = 30;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], WordOff};
    endfunction

endpackage

// File: rtl/mmu_dread_if.sv
// Pipeline-side read port, snoop port and bus read channel of the data-read MMU.
interface mmu_dread_if;

    logic        flush;
    logic        data_rden;
    logic [31:0] data_riaddr;
    logic        data_rvalid;
    logic [31:0] data_roaddr;
    logic [31:0] data_rdata;
    logic        mmu_wait;
    logic        snoop_w_en;
    logic [31:0] snoop_w_addr;
    logic        bus_arvalid;
    logic        bus_arready;
    logic [31:0] bus_araddr;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    // The MMU masters the bus and answers the pipeline.
    modport master (
        input  flush, data_rden, data_riaddr, snoop_w_en, snoop_w_addr,
        input  bus_arready, bus_rvalid, bus_rdata,
        output data_rvalid, data_roaddr, data_rdata, mmu_wait,
        output bus_arvalid, bus_araddr
    );

    modport slave (
        output flush, data_rden, data_riaddr, snoop_w_en, snoop_w_addr,
        output bus_arready, bus_rvalid, bus_rdata,
        input  data_rvalid, data_roaddr, data_rdata, mmu_wait,
        input  bus_arvalid, bus_araddr
    );

endinterface

// File: rtl/dread_buf.sv
// One-word line buffer: storage, hit compare and store-snoop invalidation.
module dread_buf
    import mmu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TagW-1:0] lookup_tag,
    output logic            hit,
    output logic [31:0]     data,
    input  logic            fill_en,
    input  logic [TagW-1:0] fill_tag,
    input  logic [31:0]     fill_data,
    input  logic            snoop_en,
    input  logic [TagW-1:0] snoop_tag
);

    logic            valid_q, valid_d;
    logic [TagW-1:0] tag_q, tag_d;
    logic [31:0]     data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            tag_d   = fill_tag;
            data_d  = fill_data;
            // A store racing the fill makes the fetched word stale on arrival.
            valid_d = !(snoop_en && (snoop_tag == fill_tag));
        end else if (snoop_en && (snoop_tag == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign data = data_q;

endmodule

// File: rtl/mmu_dread.sv
// Data-read MMU: serves pipeline reads from a one-word buffer, fetching misses over the bus.
module mmu_dread
    import mmu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mmu_dread_if.master  bus
);

    mmu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] roaddr_q, roaddr_d;

    logic        buf_hit;
    logic [31:0] buf_rdata;
    logic        fill_en;
    logic        unused_snoop_off;

    assign unused_snoop_off = ^bus.snoop_w_addr[1:0];

    dread_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (bus.data_riaddr[31:2]),
        .hit        (buf_hit),
        .data       (buf_rdata),
        .fill_en    (fill_en),
        .fill_tag   (addr_q[31:2]),
        .fill_data  (bus.bus_rdata),
        .snoop_en   (bus.snoop_w_en),
        .snoop_tag  (bus.snoop_w_addr[31:2])
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        drop_d   = drop_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        roaddr_d = roaddr_q;
        fill_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.data_rden && !bus.flush) begin
                    if (buf_hit) begin
                        rvalid_d = 1'b1;
                        rdata_d  = buf_rdata;
                        roaddr_d = bus.data_riaddr;
                    end else begin
                        state_d = StAddr;
                        addr_d  = bus.data_riaddr;
                    end
                end
            end
            StAddr: begin
                // Flush only marks the result; the address phase must still complete.
                if (bus.flush) drop_d = 1'b1;
                if (bus.bus_arready) state_d = StData;
            end
            StData: begin
                if (bus.flush) drop_d = 1'b1;
                if (bus.bus_rvalid) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                    drop_d  = 1'b0;
                    if (!(drop_q || bus.flush)) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus.bus_rdata;
                        roaddr_d = addr_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            drop_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            roaddr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            drop_q   <= drop_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            roaddr_q <= roaddr_d;
        end
    end

    assign bus.data_rvalid = rvalid_q;
    assign bus.data_rdata  = rdata_q;
    assign bus.data_roaddr = roaddr_q;
    assign bus.mmu_wait    = (state_q != StIdle);
    assign bus.bus_arvalid = (state_q == StAddr);
    assign bus.bus_araddr  = word_align(addr_q);

endmodule
